shift_rows_stream: RTL

//  Streaming, parametrised ShiftRows/InvShiftRows stage for the Rijndael datapath.

---
 rtl/shift_rows_stream.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/shift_rows_stream.sv
// ============================================================================
// shift_rows_stream : streaming ShiftRows / InvShiftRows, Nb = 4/6/8, skid-buffered
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_rows_stream #(
  parameter int NB_MAX = 8,
  parameter int TAG_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*NB_MAX-1:0]  in_data,
  input  logic [1:0]            in_nb,
  input  logic                  in_inv,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*NB_MAX-1:0]  out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic                  out_err
);

  localparam int W = 32 * NB_MAX;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [W-1:0]     out_data_q, out_data_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_err_q, out_err_d;
  logic [W-1:0]     skid_data_q, skid_data_d;
  logic [TAG_W-1:0] skid_tag_q, skid_tag_d;
  logic             skid_err_q, skid_err_d;

  logic [W-1:0]     xf_data;
  logic             xf_err;
  logic             accept;

  assign accept = in_valid & in_ready_q;

  // Byte permutation of the incoming beat; applied before the beat is stored.
  always_comb begin
    int nb;
    int off;
    int src;
    xf_data = '0;
    xf_err  = 1'b0;
    off     = 0;
    src     = 0;
    case (in_nb)
      2'b00:   nb = 4;
      2'b01:   nb = 6;
      default: nb = 8;
    endcase
    if ((in_nb == 2'b11) || (nb > NB_MAX)) begin
      xf_data = in_data;
      xf_err  = 1'b1;
    end else begin
      for (int r = 0; r < 4; r++) begin
        // Row offsets are {0,1,2,3}, except Nb=8 where rows 2/3 shift by 3/4.
        off = ((nb == 8) && (r >= 2)) ? r + 1 : r;
        for (int c = 0; c < NB_MAX; c++) begin
          if (c < nb) begin
            if (in_inv) begin
              src = c - off;
              if (src < 0) src = src + nb;
            end else begin
              src = c + off;
              if (src >= nb) src = src - nb;
            end
            xf_data[W-1-32*c-8*r -: 8] = in_data[W-1-32*src-8*r -: 8];
          end
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_tag_d   = out_tag_q;
    out_err_d   = out_err_q;
    skid_data_d = skid_data_q;
    skid_tag_d  = skid_tag_q;
    skid_err_d  = skid_err_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          out_data_d = xf_data;
          out_tag_d  = in_tag;
          out_err_d  = xf_err;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (accept && out_ready) begin
          out_data_d = xf_data;
          out_tag_d  = in_tag;
          out_err_d  = xf_err;
        end else if (accept) begin
          skid_data_d = xf_data;
          skid_tag_d  = in_tag;
          skid_err_d  = xf_err;
          state_d     = TWO;
        end else if (out_ready) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_ready) begin
          out_data_d = skid_data_q;
          out_tag_d  = skid_tag_q;
          out_err_d  = skid_err_q;
          state_d    = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Registered ready: looks one state ahead so backpressure never goes combinational.
    in_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_err_q   <= out_err_d;
      skid_data_q <= skid_data_d;
      skid_tag_q  <= skid_tag_d;
      skid_err_q  <= skid_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_err   = out_err_q;

endmodule

`default_nettype wire
